// File: rtl/coax_rx_frame_ctrl.sv
// coax_rx_frame_ctrl
// Frames bit-timer sample strobes into 10-bit words. The controller hunts for
// a run of ones followed by a zero delimiter. It then repeats this slot
// sequence: a sync slot, 10 data slots (MSB first) and a parity slot. A zero
// in the sync slot ends the message. Whenever a message ends or lock is lost,
// the bit timer is re-armed through bit_timer_reset.
// Optional feature macro: COAX_RX_PARITY_CHECK_EN (even-parity check on each word).
module coax_rx_frame_ctrl #(
  parameter int START_BITS = 5,
  parameter int END_HOLD   = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       rx,
  input  logic       sample,
  input  logic       synchronized,
  output logic       bit_timer_reset,
  output logic       active,
  output logic [9:0] data,
  output logic       data_valid,
  output logic       parity_error,
  output logic       loss_error
);

  localparam int CNT_W  = $clog2(START_BITS + 1);
  localparam int HOLD_W = (END_HOLD > 1) ? $clog2(END_HOLD) : 1;

  typedef enum logic [2:0] {
    S_HUNT,
    S_SYNC,
    S_DATA,
    S_PARITY,
    S_END
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [3:0]         idx_q, idx_d;
  logic [9:0]         shift_q, shift_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic [9:0]         data_q, data_d;
  logic               dv_q, dv_d;
  logic               pe_q, pe_d;
  logic               le_q, le_d;
  logic               bit_ev;
  logic               in_msg;

  // The start-run counter saturates at the delimiter threshold and does not wrap.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_W'(START_BITS)) ? v : v + 1'b1;
  endfunction

`ifdef COAX_RX_PARITY_CHECK_EN
  // A correct word has even parity over the 10 data bits plus the parity bit.
  function automatic logic parity_of(input logic [9:0] w, input logic p);
    return ^{w, p};
  endfunction
`endif

  assign bit_ev = sample & synchronized;
  assign in_msg = (state_q == S_SYNC) || (state_q == S_DATA) || (state_q == S_PARITY);

  // Next-state, deserializer and output-strobe decode
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    hold_d  = hold_q;
    data_d  = data_q;
    dv_d    = 1'b0;
    pe_d    = 1'b0;
    le_d    = 1'b0;
    case (state_q)
      S_HUNT: begin
        if (!synchronized) begin
          cnt_d = '0;
        end else if (bit_ev) begin
          if (rx) begin
            cnt_d = sat_inc(cnt_q);
          end else if (cnt_q == CNT_W'(START_BITS)) begin
            state_d = S_SYNC;
            cnt_d   = '0;
          end else begin
            cnt_d = '0;
          end
        end
      end
      S_SYNC: begin
        if (bit_ev) begin
          if (rx) begin
            state_d = S_DATA;
            idx_d   = 4'd9;
          end else begin
            state_d = S_END;
            hold_d  = '0;
          end
        end
      end
      S_DATA: begin
        if (bit_ev) begin
          shift_d = {shift_q[8:0], rx};
          if (idx_q == 4'd0) begin
            state_d = S_PARITY;
          end else begin
            idx_d = idx_q - 4'd1;
          end
        end
      end
      S_PARITY: begin
        if (bit_ev) begin
          data_d  = shift_q;
          dv_d    = 1'b1;
`ifdef COAX_RX_PARITY_CHECK_EN
          pe_d    = parity_of(shift_q, rx);
`endif
          state_d = S_SYNC;
        end
      end
      S_END: begin
        // Inputs are ignored here; only the hold timer advances.
        if (hold_q == HOLD_W'(END_HOLD - 1)) begin
          state_d = S_HUNT;
          hold_d  = '0;
          cnt_d   = '0;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      default: state_d = S_HUNT;
    endcase

    // Losing lock mid-message overrides any bit event in the same cycle.
    if (in_msg && !synchronized) begin
      state_d = S_END;
      hold_d  = '0;
      shift_d = '0;
      data_d  = data_q;
      dv_d    = 1'b0;
      pe_d    = 1'b0;
      le_d    = 1'b1;
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_HUNT;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      hold_q  <= '0;
      data_q  <= '0;
      dv_q    <= 1'b0;
      pe_q    <= 1'b0;
      le_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      hold_q  <= hold_d;
      data_q  <= data_d;
      dv_q    <= dv_d;
      pe_q    <= pe_d;
      le_q    <= le_d;
    end
  end

  assign active          = in_msg;
  assign bit_timer_reset = (state_q == S_END);
  assign data            = data_q;
  assign data_valid      = dv_q;
  assign parity_error    = pe_q;
  assign loss_error      = le_q;

endmodule
